// File: rtl/ram_write_sequencer.sv
// ram_write_sequencer
//   Drives a bank of WIDTH parallel 1024x1 ECL RAM chips that share address,
//   enable and write pins. Single-cycle read/write requests become pin-level
//   RAM cycles with setup, write-pulse and hold phases. A bulk clear zeroes
//   all 1024 words back to back. With RAM_WRITE_VERIFY_EN defined, every
//   write is read back and compared, and the first mismatch address is kept.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (accepted on valid & ready)
//   req_write               1 = write, 0 = read
//   req_addr, req_data      word address (bit 9 -> chip pin a0), write data
//   rsp_valid, rsp_data     one-cycle read-data pulse, data held until next read
//   clr_start, clr_busy     bulk clear start pulse (IDLE only), clear running
//   verify_err, verify_addr sticky readback mismatch flag and first bad address
//   ram_a, ram_d            registered RAM address / data-in pins
//   ram_nen, ram_nwrite     registered RAM enable / write strobe, active low
//   ram_q                   RAM data-out pins (0 while disabled or writing)
//
// Configuration macro: RAM_WRITE_VERIFY_EN (adds the VWAIT readback phase).

module ram_write_sequencer #(
  parameter int unsigned WIDTH     = 36,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned READ_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [9:0]       req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             verify_err,
  output logic [9:0]       verify_addr,
  output logic [9:0]       ram_a,
  output logic [WIDTH-1:0] ram_d,
  output logic             ram_nen,
  output logic             ram_nwrite,
  input  logic [WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    WSETUP,
    WPULSE,
    WHOLD,
    RWAIT,
    RSP
`ifdef RAM_WRITE_VERIFY_EN
    , VWAIT
`endif
  } state_t;

  state_t            state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [9:0]        addr_n;
  logic [WIDTH-1:0]  data_n;
  logic              busy_n;
  logic              capture;
  logic              wr_done;
  logic              nen_n, nwrite_n;
  logic              verr_set;

  // clr_start outranks a same-cycle request, so it also blocks ready.
  assign req_ready = (state == IDLE) && !clr_busy && !clr_start;

  always_comb begin
    state_n  = state;
    addr_n   = ram_a;
    data_n   = ram_d;
    busy_n   = clr_busy;
    capture  = 1'b0;
    wr_done  = 1'b0;
    verr_set = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          addr_n  = '0;
          data_n  = '0;
          busy_n  = 1'b1;
          state_n = WSETUP;
        end else if (req_valid) begin
          addr_n = req_addr;
          if (req_write) begin
            data_n  = req_data;
            state_n = WSETUP;
          end else begin
            state_n = RWAIT;
          end
        end
      end
      WSETUP: if (cnt == '0) state_n = WPULSE;
      WPULSE: if (cnt == '0) state_n = WHOLD;
      WHOLD: begin
        if (cnt == '0) begin
`ifdef RAM_WRITE_VERIFY_EN
          state_n = VWAIT;
`else
          wr_done = 1'b1;
`endif
        end
      end
      RWAIT: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_n = RSP;
        end
      end
      RSP: state_n = IDLE;
`ifdef RAM_WRITE_VERIFY_EN
      VWAIT: begin
        if (cnt == '0) begin
          wr_done = 1'b1;
          if ((ram_q != ram_d) && !verify_err) verr_set = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // End of one write cycle: step the clear address or return to IDLE.
    // The clear stops at 1023 without wrapping the address.
    if (wr_done) begin
      if (clr_busy && (ram_a != 10'h3FF)) begin
        addr_n  = ram_a + 10'd1;
        state_n = WSETUP;
      end else begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    end
  end

  // Phase counter counts down to 0 and reloads whenever a state is entered.
  always_comb begin
    cnt_n = '0;
    if (state_n != state) begin
      case (state_n)
        WSETUP:  cnt_n = 16'(SETUP_CYC - 1);
        WPULSE:  cnt_n = 16'(PULSE_CYC - 1);
        WHOLD:   cnt_n = 16'(HOLD_CYC - 1);
        RWAIT:   cnt_n = 16'(READ_CYC - 1);
`ifdef RAM_WRITE_VERIFY_EN
        VWAIT:   cnt_n = 16'(READ_CYC - 1);
`endif
        default: cnt_n = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_n = cnt - 16'd1;
    end
  end

  // Pin levels are decoded from the next state and registered with it,
  // so the pins line up with the state without any input-to-pin path.
  always_comb begin
    nen_n    = 1'b1;
    nwrite_n = 1'b1;
    case (state_n)
      WSETUP, WHOLD, RWAIT: nen_n = 1'b0;
`ifdef RAM_WRITE_VERIFY_EN
      VWAIT:                nen_n = 1'b0;
`endif
      WPULSE: begin
        nen_n    = 1'b0;
        nwrite_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ram_a      <= '0;
      ram_d      <= '0;
      ram_nen    <= 1'b1;
      ram_nwrite <= 1'b1;
      clr_busy   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ram_a      <= addr_n;
      ram_d      <= data_n;
      ram_nen    <= nen_n;
      ram_nwrite <= nwrite_n;
      clr_busy   <= busy_n;
      rsp_valid  <= (state_n == RSP);
      if (capture) rsp_data <= ram_q;
    end
  end

`ifdef RAM_WRITE_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_err  <= 1'b0;
      verify_addr <= '0;
    end else if (verr_set) begin
      verify_err  <= 1'b1;
      verify_addr <= ram_a;
    end
  end
`else
  assign verify_err  = 1'b0;
  assign verify_addr = '0;
`endif

endmodule

// File: tb/tb_ram_write_sequencer.sv
module tb_ram_write_sequencer;

  localparam int W = 36;
`ifdef RAM_WRITE_VERIFY_EN
  localparam int WR_CYC = 7;
  localparam logic [15:0] NEN_MASK = 16'h00FE;
`else
  localparam int WR_CYC = 5;
  localparam logic [15:0] NEN_MASK = 16'h003E;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, clr_start = 1'b0;
  logic [9:0]    req_addr = '0;
  logic [W-1:0]  req_data = '0;
  logic          req_ready, rsp_valid, clr_busy, verify_err, ram_nen, ram_nwrite;
  logic [W-1:0]  rsp_data, ram_d, ram_q;
  logic [9:0]    verify_addr, ram_a;

  ram_write_sequencer #(.WIDTH(W), .SETUP_CYC(2), .PULSE_CYC(2), .HOLD_CYC(1), .READ_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .verify_err(verify_err), .verify_addr(verify_addr),
    .ram_a(ram_a), .ram_d(ram_d), .ram_nen(ram_nen), .ram_nwrite(ram_nwrite),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural RAM bank: writes while nen & nwrite low, drives 0 unless reading.
  logic [W-1:0] mem [0:1023];
  logic [W-1:0] stuck_mask = '1;
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) if (!ram_nen && !ram_nwrite) mem[ram_a] <= ram_d;
  assign ram_q = (!ram_nen && ram_nwrite) ? (mem[ram_a] & stuck_mask) : '0;

  int pulses = 0;
  bit count_en = 1'b0;
  always @(negedge ram_nwrite) if (count_en) pulses++;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request and return just after the accepting edge.
  task automatic do_req(input logic w, input logic [9:0] a, input logic [W-1:0] d);
    bit ok = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    check("accept_timeout", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  typedef struct {
    bit           wr;
    logic [9:0]   addr;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  nen_mask, nwr_mask;
    int           a_bad, lat, cyc;
    logic [W-1:0] last_rsp;
    logic [9:0]   fall_addr;
    bit           prev_busy, got;
    int           ready_viol;

    vecs[0] = '{1'b1, 10'h2A5, 36'hABCDE0123, 36'h0};
    vecs[1] = '{1'b0, 10'h2A5, 36'h0,         36'hABCDE0123};
    vecs[2] = '{1'b1, 10'h000, 36'hFFFFFFFFF, 36'h0};
    vecs[3] = '{1'b0, 10'h000, 36'h0,         36'hFFFFFFFFF};
    vecs[4] = '{1'b0, 10'h3FF, 36'h0,         36'h123456789};
    vecs[5] = '{1'b1, 10'h2A5, 36'h000000001, 36'h0};
    vecs[6] = '{1'b0, 10'h2A5, 36'h0,         36'h000000001};
    vecs[7] = '{1'b0, 10'h001, 36'h0,         36'h0};

    // 1: reset values
    repeat (3) @(negedge clk);
    check("rst_nen", {63'd0, ram_nen}, 64'd1);
    check("rst_nwrite", {63'd0, ram_nwrite}, 64'd1);
    check("rst_ram_a", {54'd0, ram_a}, 64'd0);
    check("rst_ram_d", {28'd0, ram_d}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", {28'd0, rsp_data}, 64'd0);
    check("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
    check("rst_verify", {53'd0, verify_err, verify_addr}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);

    // 2: write pin timing @0x3FF
    do_req(1'b1, 10'h3FF, 36'h123456789);
    nen_mask = '0; nwr_mask = '0; a_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!ram_nen) begin
        nen_mask[c] = 1'b1;
        if (ram_a != 10'h3FF || ram_d != 36'h123456789) a_bad++;
      end
      if (!ram_nwrite) nwr_mask[c] = 1'b1;
    end
    check("wr_nen_cycles", {48'd0, nen_mask}, {48'd0, NEN_MASK});
    check("wr_nwrite_cycles", {48'd0, nwr_mask}, 64'h18);
    check("wr_addr_stable", 64'(a_bad), 64'd0);

    // 3: table of writes and reads
    last_rsp = '0;
    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].data);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(negedge clk);
        if (vecs[i].wr ? req_ready : rsp_valid) lat = c;
      end
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_wr_latency", i), 64'(lat), 64'(WR_CYC + 1));
        check($sformatf("vec%0d_rsp_hold", i), {28'd0, rsp_data}, {28'd0, last_rsp});
      end else begin
        check($sformatf("vec%0d_rd_latency", i), 64'(lat), 64'd3);
        check($sformatf("vec%0d_rd_data", i), {28'd0, rsp_data}, {28'd0, vecs[i].exp});
        @(negedge clk);
        check($sformatf("vec%0d_rsp_pulse", i), {63'd0, rsp_valid}, 64'd0);
        last_rsp = vecs[i].exp;
      end
    end

    // 4: clear beats a same-cycle read request; the read returns 0 afterwards
    @(negedge clk);
    clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h2A5;
    #1;
    check("clr_priority_ready", {63'd0, req_ready}, 64'd0);
    pulses = 0; count_en = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    check("clr_busy_set", {63'd0, clr_busy}, 64'd1);
    prev_busy = 1'b1; got = 1'b0; fall_addr = '0; ready_viol = 0; cyc = 0;
    while (!got && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 100) clr_start = 1'b1;
      if (cyc == 101) clr_start = 1'b0;
      if (clr_busy && req_ready) ready_viol++;
      if (prev_busy && !clr_busy) fall_addr = ram_a;
      prev_busy = clr_busy;
      if (rsp_valid) got = 1'b1;
      else if (req_ready && req_valid) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    count_en = 1'b0;
    check("clr_rsp_seen", {63'd0, got}, 64'd1);
    check("clr_pulses", 64'(pulses), 64'd1024);
    check("clr_last_addr", {54'd0, fall_addr}, 64'h3FF);
    check("clr_ready_stall", 64'(ready_viol), 64'd0);
    check("clr_read_data", {28'd0, rsp_data}, 64'd0);
    check("clr_busy_done", {63'd0, clr_busy}, 64'd0);

    // 5: reset during the write pulse
    do_req(1'b1, 10'h155, 36'h5);
    repeat (3) @(negedge clk);
    check("mid_pulse_nwrite", {63'd0, ram_nwrite}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_nwrite", {63'd0, ram_nwrite}, 64'd1);
    check("async_nen", {63'd0, ram_nen}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_nen", {63'd0, ram_nen}, 64'd1);

`ifdef RAM_WRITE_VERIFY_EN
    // 6: stuck-at-0 data bit 5 caught by readback; first address kept
    stuck_mask = ~(36'd1 << 5);
    do_req(1'b1, 10'h010, '1);
    repeat (WR_CYC + 1) @(negedge clk);
    check("verify_err_set", {63'd0, verify_err}, 64'd1);
    check("verify_addr_first", {54'd0, verify_addr}, 64'h010);
    do_req(1'b1, 10'h020, '1);
    repeat (WR_CYC + 1) @(negedge clk);
    check("verify_err_sticky", {63'd0, verify_err}, 64'd1);
    check("verify_addr_kept", {54'd0, verify_addr}, 64'h010);
`else
    check("verify_err_tied", {63'd0, verify_err}, 64'd0);
    check("verify_addr_tied", {54'd0, verify_addr}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
